// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles every signal between the two cache miss ports, the arbiter and the
// shared 128-bit line memory, plus the arbiter's statistics outputs.
//
//   slave  : arbiter view (cache requests and memory responses in; grants,
//            completion strobes, memory request and statistics out)
//   master : environment view (caches + memory), the mirror image of slave
//
// Signals
//   i_read/i_addr/i_ready                 I-cache miss port (read only)
//   d_read/d_write/d_addr/d_wdata/d_ready D-cache miss port
//   rdata                                 memory read line broadcast to both caches
//   mem_read/mem_write/mem_addr/mem_wdata registered memory request
//   mem_rdata/mem_ready                   memory response
//   stat_i_grant/stat_d_grant/stat_conflict  saturating statistics (STAT_W bits)
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int STAT_W = 16
);
    // I-cache miss port
    logic              i_read;
    logic [27:0]       i_addr;
    logic              i_ready;

    // D-cache miss port
    logic              d_read;
    logic              d_write;
    logic [27:0]       d_addr;
    logic [127:0]      d_wdata;
    logic              d_ready;

    // Read line shared by both caches
    logic [127:0]      rdata;

    // Memory side
    logic              mem_read;
    logic              mem_write;
    logic [27:0]       mem_addr;
    logic [127:0]      mem_wdata;
    logic [127:0]      mem_rdata;
    logic              mem_ready;

    // Statistics
    logic [STAT_W-1:0] stat_i_grant;
    logic [STAT_W-1:0] stat_d_grant;
    logic [STAT_W-1:0] stat_conflict;

    modport slave (
        input  i_read, i_addr,
        output i_ready,
        input  d_read, d_write, d_addr, d_wdata,
        output d_ready,
        output rdata,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        output stat_i_grant, stat_d_grant, stat_conflict
    );

    modport master (
        output i_read, i_addr,
        input  i_ready,
        output d_read, d_write, d_addr, d_wdata,
        input  d_ready,
        input  rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        input  stat_i_grant, stat_d_grant, stat_conflict
    );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-client arbiter placing I-cache and D-cache line misses onto one shared
// 128-bit line memory, one transaction at a time. The granted request is
// registered toward memory; the memory completion strobe is routed back to the
// owner only. Keeps saturating per-client grant and conflict counters.
//
// Parameters
//   HOLD_CYC  cycles spent in HOLD after a completion (served client masked)
//   D_FIRST   winner of the first conflict after reset (1: D-cache, 0: I-cache)
//   STAT_W    statistics counter width
//
// Ports
//   clk         clock, rising edge
//   proc_reset  synchronous active-high reset
//   bus         mem_arbiter_if.slave: cache ports, memory ports, statistics
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int HOLD_CYC = 1,
    parameter int D_FIRST  = 1,
    parameter int STAT_W   = 16
) (
    input  logic          clk,
    input  logic          proc_reset,
    mem_arbiter_if.slave  bus
);

    localparam int HC_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    // Per-client mask armed at completion; survives HOLD and exactly one IDLE
    // evaluation so a client still holding its request is not re-granted.
    logic              r_mask_i;
    logic              r_mask_d;

    // Winner of the most recent conflict; only conflicts update it, so a
    // non-contended grant does not disturb the round robin order.
    logic              r_last_conf_d;

    logic [HC_W-1:0]   r_hold_cnt;

    logic              r_mem_read;
    logic              r_mem_write;
    logic [27:0]       r_mem_addr;
    logic [127:0]      r_mem_wdata;

    logic              w_req_i;
    logic              w_req_d;
    logic              w_grant_i;
    logic              w_grant_d;
    logic              w_done;
    logic              w_conflict;
    logic              w_hold_last;

    logic [2:0]              w_stat_inc;
    logic [2:0][STAT_W-1:0]  w_stat;

    // -------------------------------------------------------------------------
    // Request qualification
    // -------------------------------------------------------------------------
    assign w_req_i     = bus.i_read & ~r_mask_i;
    assign w_req_d     = (bus.d_read | bus.d_write) & ~r_mask_d;
    assign w_conflict  = (r_state == ST_IDLE) & w_req_i & w_req_d;
    assign w_hold_last = (r_hold_cnt == HC_W'(HOLD_CYC - 1));

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and grant decode
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        w_done       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_req_i && w_req_d) begin
                    // Contended: the client that lost the last conflict wins.
                    if (r_last_conf_d) begin
                        w_grant_i = 1'b1;
                    end else begin
                        w_grant_d = 1'b1;
                    end
                end else if (w_req_i) begin
                    w_grant_i = 1'b1;
                end else if (w_req_d) begin
                    w_grant_d = 1'b1;
                end

                if (w_grant_i) begin
                    w_state_next = ST_BUSY_I;
                end else if (w_grant_d) begin
                    w_state_next = ST_BUSY_D;
                end
            end

            ST_BUSY_I, ST_BUSY_D: begin
                if (bus.mem_ready) begin
                    w_done       = 1'b1;
                    w_state_next = (HOLD_CYC == 0) ? ST_IDLE : ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (w_hold_last) begin
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // HOLD counter, masks and round robin flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_hold_cnt    <= '0;
            r_mask_i      <= 1'b0;
            r_mask_d      <= 1'b0;
            r_last_conf_d <= (D_FIRST == 0);
        end else begin
            if (r_state == ST_HOLD) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end else begin
                r_hold_cnt <= '0;
            end

            if (w_done) begin
                r_mask_i <= (r_state == ST_BUSY_I);
                r_mask_d <= (r_state == ST_BUSY_D);
            end else if (r_state == ST_IDLE) begin
                // The mask has now covered one IDLE evaluation.
                r_mask_i <= 1'b0;
                r_mask_d <= 1'b0;
            end

            if (w_conflict) begin
                r_last_conf_d <= w_grant_d;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered memory request. Captured at the grant edge and held until
    // the edge following mem_ready.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_grant_i) begin
            r_mem_read  <= 1'b1;
            r_mem_write <= 1'b0;
            r_mem_addr  <= bus.i_addr;
        end else if (w_grant_d) begin
            // An illegal read+write request is carried out as a write.
            r_mem_read  <= ~bus.d_write;
            r_mem_write <= bus.d_write;
            r_mem_addr  <= bus.d_addr;
            r_mem_wdata <= bus.d_wdata;
        end else if (w_done) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Saturating statistics: 0 = I grants, 1 = D grants, 2 = IDLE conflicts
    // -------------------------------------------------------------------------
    assign w_stat_inc = {w_conflict, w_grant_d, w_grant_i};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_stat
            logic [STAT_W-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (proc_reset) begin
                    r_cnt <= '0;
                end else if (w_stat_inc[gi] && (r_cnt != {STAT_W{1'b1}})) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_stat[gi] = r_cnt;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Completion is steered only to the owner; mem_ready outside BUSY is dropped.
    assign bus.i_ready       = bus.mem_ready & (r_state == ST_BUSY_I);
    assign bus.d_ready       = bus.mem_ready & (r_state == ST_BUSY_D);
    assign bus.rdata         = bus.mem_rdata;

    assign bus.mem_read      = r_mem_read;
    assign bus.mem_write     = r_mem_write;
    assign bus.mem_addr      = r_mem_addr;
    assign bus.mem_wdata     = r_mem_wdata;

    assign bus.stat_i_grant  = w_stat[0];
    assign bus.stat_d_grant  = w_stat[1];
    assign bus.stat_conflict = w_stat[2];

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int SW  = 4;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic proc_reset;

    always #5 clk = ~clk;

    mem_arbiter_if #(.STAT_W(SW)) bus ();

    mem_arbiter #(
        .HOLD_CYC (1),
        .D_FIRST  (1),
        .STAT_W   (SW)
    ) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .bus        (bus)
    );

    typedef struct packed {
        logic         owner_d;
        logic         wr;
        logic [27:0]  addr;
        logic [127:0] wdata;
    } txn_t;

    txn_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   txn_no = 0;
    bit   mem_en = 1'b1;
    bit   inject_ready = 1'b0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] line_of(input logic [27:0] a);
        return {4{4'hC, a}};
    endfunction

    // Memory model: pops the expected request when a new one appears, checks
    // it is held stable, answers after LAT cycles and checks the routing.
    initial begin : mem_model
        int   wait_cnt;
        txn_t cur;
        wait_cnt = -1;
        cur = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ready = inject_ready;
            if (!mem_en || proc_reset) begin
                wait_cnt = -1;
            end else if (wait_cnt > 0) begin
                check_eq("addr_stable", bus.mem_addr, cur.addr);
                check_eq("op_held", bus.mem_read | bus.mem_write, 1'b1);
                wait_cnt--;
                if (wait_cnt == 0) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = line_of(cur.addr);
                    #1;
                    check_eq("i_ready", bus.i_ready, !cur.owner_d);
                    check_eq("d_ready", bus.d_ready, cur.owner_d);
                    if (!cur.wr) check_eq("rdata", bus.rdata, line_of(cur.addr));
                    txn_no++;
                    $display("txn %0d: %s %s addr=%07h", txn_no, cur.owner_d ? "D" : "I",
                             cur.wr ? "write" : "read", cur.addr);
                    wait_cnt = -1;
                end
            end else if (bus.mem_read || bus.mem_write) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_txn", sb.size(), 1);
                end else begin
                    cur = sb.pop_front();
                    check_eq("mem_write", bus.mem_write, cur.wr);
                    check_eq("mem_read", bus.mem_read, !cur.wr);
                    check_eq("mem_addr", bus.mem_addr, cur.addr);
                    if (cur.wr) check_eq("mem_wdata", bus.mem_wdata, cur.wdata);
                    wait_cnt = LAT - 1;
                end
            end
        end
    end

    task automatic i_txn(input logic [27:0] a, input int extra);
        bit got;
        got = 1'b0;
        @(negedge clk);
        bus.i_read = 1'b1;
        bus.i_addr = a;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            #2;
            if (bus.i_ready) got = 1'b1;
        end
        check_eq("i_served", got, 1'b1);
        repeat (1 + extra) @(negedge clk);
        bus.i_read = 1'b0;
    endtask

    task automatic d_txn(input logic wr, input logic [27:0] a, input logic [127:0] wd);
        bit got;
        got = 1'b0;
        @(negedge clk);
        bus.d_write = wr;
        bus.d_read  = !wr;
        bus.d_addr  = a;
        bus.d_wdata = wd;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            #2;
            if (bus.d_ready) got = 1'b1;
        end
        check_eq("d_served", got, 1'b1);
        @(negedge clk);
        bus.d_write = 1'b0;
        bus.d_read  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        proc_reset  = 1'b1;
        bus.i_read  = 1'b0;
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        repeat (2) @(negedge clk);
        proc_reset  = 1'b0;
    endtask

    task automatic gap();
        repeat (3) @(negedge clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [127:0] pat;
        proc_reset  = 1'b1;
        bus.i_read  = 1'b0;
        bus.i_addr  = '0;
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;

        // Reset state
        do_reset();
        #2;
        check_eq("rst_mem_read", bus.mem_read, 1'b0);
        check_eq("rst_mem_write", bus.mem_write, 1'b0);
        check_eq("rst_mem_addr", bus.mem_addr, 28'h0);
        check_eq("rst_mem_wdata", bus.mem_wdata, 128'h0);
        check_eq("rst_i_ready", bus.i_ready, 1'b0);
        check_eq("rst_d_ready", bus.d_ready, 1'b0);
        check_eq("rst_stat_i", bus.stat_i_grant, 0);
        check_eq("rst_stat_d", bus.stat_d_grant, 0);
        check_eq("rst_stat_c", bus.stat_conflict, 0);

        // 1. I-only read; mem_read visible one cycle after the request is raised
        sb.push_back('{owner_d: 1'b0, wr: 1'b0, addr: 28'h0000123, wdata: '0});
        fork
            i_txn(28'h0000123, 0);
            begin
                @(negedge clk);
                @(negedge clk);
                #3;
                check_eq("t1_mem_read_rise", bus.mem_read, 1'b1);
                check_eq("t1_mem_addr", bus.mem_addr, 28'h0000123);
            end
        join
        gap();
        check_eq("t1_stat_i", bus.stat_i_grant, 1);
        check_eq("t1_stat_d", bus.stat_d_grant, 0);

        // 2. D write-back then allocate of the next line
        do_reset();
        pat = {16{8'hA5}};
        sb.push_back('{owner_d: 1'b1, wr: 1'b1, addr: 28'h0000400, wdata: pat});
        sb.push_back('{owner_d: 1'b1, wr: 1'b0, addr: 28'h0000401, wdata: '0});
        d_txn(1'b1, 28'h0000400, pat);
        d_txn(1'b0, 28'h0000401, 128'h0);
        gap();
        check_eq("t2_stat_d", bus.stat_d_grant, 2);
        check_eq("t2_stat_i", bus.stat_i_grant, 0);

        // 3. Conflicts from reset: D first, then the next conflict goes to I
        do_reset();
        sb.push_back('{owner_d: 1'b1, wr: 1'b0, addr: 28'h0000800, wdata: '0});
        sb.push_back('{owner_d: 1'b0, wr: 1'b0, addr: 28'h0000900, wdata: '0});
        fork
            i_txn(28'h0000900, 0);
            d_txn(1'b0, 28'h0000800, 128'h0);
        join
        gap();
        check_eq("t3_conflict_1", bus.stat_conflict, 1);
        sb.push_back('{owner_d: 1'b0, wr: 1'b0, addr: 28'h0000A00, wdata: '0});
        sb.push_back('{owner_d: 1'b1, wr: 1'b1, addr: 28'h0000B00, wdata: {8{16'h1234}}});
        fork
            i_txn(28'h0000A00, 0);
            d_txn(1'b1, 28'h0000B00, {8{16'h1234}});
        join
        gap();
        check_eq("t3_conflict_2", bus.stat_conflict, 2);
        check_eq("t3_stat_i", bus.stat_i_grant, 2);
        check_eq("t3_stat_d", bus.stat_d_grant, 2);

        // 4. Request held past completion (through HOLD and the masked IDLE)
        do_reset();
        sb.push_back('{owner_d: 1'b0, wr: 1'b0, addr: 28'h0000C00, wdata: '0});
        i_txn(28'h0000C00, 2);
        for (int k = 0; k < 5; k++) begin
            #2;
            check_eq("t4_no_regrant", bus.mem_read | bus.mem_write, 1'b0);
            @(negedge clk);
        end
        check_eq("t4_stat_i", bus.stat_i_grant, 1);

        // 5. Reset in the middle of a D transaction; late mem_ready ignored
        do_reset();
        mem_en = 1'b0;
        @(negedge clk);
        bus.d_read = 1'b1;
        bus.d_addr = 28'h0000D00;
        @(negedge clk);
        #2;
        check_eq("t5_busy_mem_read", bus.mem_read, 1'b1);
        proc_reset = 1'b1;
        @(negedge clk);
        #2;
        check_eq("t5_rst_mem_read", bus.mem_read, 1'b0);
        proc_reset = 1'b0;
        bus.d_read = 1'b0;
        @(posedge clk);
        #1;
        inject_ready = 1'b1;
        @(negedge clk);
        #2;
        check_eq("t5_d_ready", bus.d_ready, 1'b0);
        check_eq("t5_i_ready", bus.i_ready, 1'b0);
        @(posedge clk);
        #1;
        inject_ready = 1'b0;
        @(negedge clk);
        #2;
        check_eq("t5_mem_read_after", bus.mem_read, 1'b0);
        check_eq("t5_stat_d", bus.stat_d_grant, 0);
        check_eq("t5_stat_c", bus.stat_conflict, 0);
        mem_en = 1'b1;

        // 6. Saturation of the 4-bit I grant counter
        do_reset();
        for (int n = 0; n < (1 << SW) + 3; n++) begin
            sb.push_back('{owner_d: 1'b0, wr: 1'b0, addr: 28'h0001000 + 28'(n), wdata: '0});
            i_txn(28'h0001000 + 28'(n), 0);
            if (n == (1 << SW) - 2) begin
                gap();
                check_eq("t6_stat_i_max", bus.stat_i_grant, (1 << SW) - 1);
            end
        end
        gap();
        check_eq("t6_stat_i_sat", bus.stat_i_grant, 4'hF);
        check_eq("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
